// File: rtl/mod5_serial_tx.sv
// MSB-first parallel-to-serial transmitter that tracks the running value-mod-5
// of the emitted bits and flags divisibility when the word completes.
module mod5_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out,
    output logic             out_valid,
    output logic [2:0]       residue,
    output logic             done,
    output logic             divisible
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [2:0]       res_nxt;

    // (2r + b) mod 5; out-of-range residues collapse to 0.
    function automatic logic [2:0] res_step(input logic [2:0] r, input logic b);
        case (r)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd3 : 3'd2;
            3'd2:    return b ? 3'd0 : 3'd4;
            3'd3:    return b ? 3'd2 : 3'd1;
            3'd4:    return b ? 3'd4 : 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    assign res_nxt  = res_step(residue, out);
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            residue   <= 3'd0;
            done      <= 1'b0;
            divisible <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    divisible <= 1'b0;
                    if (in_valid) begin
                        // out is registered, so the MSB is presented right away
                        shreg     <= in_data;
                        out       <= in_data[WIDTH-1];
                        out_valid <= 1'b1;
                        residue   <= 3'd0;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    residue <= res_nxt;
                    shreg   <= shreg << 1;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        divisible <= (res_nxt == 3'd0);
                        state     <= DONE;
                    end else begin
                        out <= shreg[WIDTH-2];
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    divisible <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    divisible <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
